led_bank_sequencer: RTL and testbench

- Free-running LED animation sequencer driving two LED banks: left bank of 13 outputs (la..lm) and right bank of 12 outputs (ra..rl).
- A 3-state Moore FSM cycles through three phases: S0 left sweep, S1 right sweep, S2 flash-all.
- It sits at the top-level panel as a self-contained status and attract display.
- It has no data inputs; it is driven only by the clock, the reset and an internal tick prescaler.

---
 rtl/led_pkg.sv | 13 +
 rtl/led_tick_gen.sv | 29 ++
 rtl/led_bank_sequencer.sv | 157 +++++++++++++++
 tb/tb_led_bank_sequencer.sv | 153 +++++++++++++++
 4 files changed

// File: rtl/led_pkg.sv
// Shared types and constants for the LED bank sequencer.
package led_pkg;

    typedef enum logic [1:0] {
        S0_LEFT  = 2'd0,
        S1_RIGHT = 2'd1,
        S2_FLASH = 2'd2
    } state_t;

    localparam int LEFT_N  = 13;
    localparam int RIGHT_N = 12;

endpackage

// File: rtl/led_tick_gen.sv
// Animation step prescaler: emits a one-cycle tick every TICK_DIV clocks.
// With TICK_DIV=1 the tick is asserted on every cycle.
module led_tick_gen #(
    parameter int TICK_DIV = 1
) (
    input  logic clk,
    input  logic reset,
    output logic tick
);

    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] cnt;

    assign tick = (cnt == CNT_LAST);

    // Count up to TICK_DIV-1, then wrap to 0 on the tick.
    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt <= '0;
        end else if (tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

endmodule

// File: rtl/led_bank_sequencer.sv
// Free-running two-bank LED animation: left sweep, right sweep, flash-all.
// Build option: define LED_ACTIVE_LOW_EN to invert all 25 outputs for
// common-anode wiring (lit = 0). The FSM is the same in both builds.
//
// state    | meaning
// ---------+------------------------------------------------
// S0_LEFT  | one left LED lit at left[pos], pos 0..12
// S1_RIGHT | one right LED lit at right[pos], pos 0..11
// S2_FLASH | all LEDs = ~pos[0], pos 0..FLASH_STEPS-1
module led_bank_sequencer
    import led_pkg::*;
#(
    parameter int TICK_DIV    = 1,
    parameter int FLASH_STEPS = 4
) (
    input  logic clk,
    input  logic reset,
    output logic la, output logic lb, output logic lc, output logic ld,
    output logic le, output logic lf, output logic lg, output logic lh,
    output logic li, output logic lj, output logic lk, output logic ll,
    output logic lm,
    output logic ra, output logic rb, output logic rc, output logic rd,
    output logic re, output logic rf, output logic rg, output logic rh,
    output logic ri, output logic rj, output logic rk, output logic rl
);

    localparam logic [3:0] LEFT_LAST  = 4'(LEFT_N - 1);
    localparam logic [3:0] RIGHT_LAST = 4'(RIGHT_N - 1);
    localparam logic [3:0] FLASH_LAST = 4'(FLASH_STEPS - 1);

    state_t              state, state_nxt;
    logic [3:0]          pos, pos_nxt;
    logic                tick;
    logic [LEFT_N-1:0]   left, left_o;
    logic [RIGHT_N-1:0]  right, right_o;

    led_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
        .clk   (clk),
        .reset (reset),
        .tick  (tick)
    );

    // State and position registers, synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= S0_LEFT;
            pos   <= '0;
        end else begin
            state <= state_nxt;
            pos   <= pos_nxt;
        end
    end

    // Next-state: advance only on tick; out-of-range pos or state recovers to S0/0.
    always_comb begin
        state_nxt = state;
        pos_nxt   = pos;
        if (tick) begin
            case (state)
                S0_LEFT: begin
                    if (pos == LEFT_LAST) begin
                        state_nxt = S1_RIGHT;
                        pos_nxt   = '0;
                    end else if (pos > LEFT_LAST) begin
                        state_nxt = S0_LEFT;
                        pos_nxt   = '0;
                    end else begin
                        pos_nxt = pos + 4'd1;
                    end
                end
                S1_RIGHT: begin
                    if (pos == RIGHT_LAST) begin
                        state_nxt = S2_FLASH;
                        pos_nxt   = '0;
                    end else if (pos > RIGHT_LAST) begin
                        state_nxt = S0_LEFT;
                        pos_nxt   = '0;
                    end else begin
                        pos_nxt = pos + 4'd1;
                    end
                end
                S2_FLASH: begin
                    if (pos >= FLASH_LAST) begin
                        state_nxt = S0_LEFT;
                        pos_nxt   = '0;
                    end else begin
                        pos_nxt = pos + 4'd1;
                    end
                end
                default: begin
                    state_nxt = S0_LEFT;
                    pos_nxt   = '0;
                end
            endcase
        end
    end

    // Moore decode of state/pos into active-high bank vectors; unused encodings give all-off.
    always_comb begin
        left  = '0;
        right = '0;
        case (state)
            S0_LEFT: begin
                if (pos <= LEFT_LAST) left[pos] = 1'b1;
            end
            S1_RIGHT: begin
                if (pos <= RIGHT_LAST) right[pos] = 1'b1;
            end
            S2_FLASH: begin
                if (pos <= FLASH_LAST) begin
                    left  = {LEFT_N{~pos[0]}};
                    right = {RIGHT_N{~pos[0]}};
                end
            end
            default: begin
                left  = '0;
                right = '0;
            end
        endcase
    end

`ifdef LED_ACTIVE_LOW_EN
    assign left_o  = ~left;
    assign right_o = ~right;
`else
    assign left_o  = left;
    assign right_o = right;
`endif

    assign la = left_o[0];
    assign lb = left_o[1];
    assign lc = left_o[2];
    assign ld = left_o[3];
    assign le = left_o[4];
    assign lf = left_o[5];
    assign lg = left_o[6];
    assign lh = left_o[7];
    assign li = left_o[8];
    assign lj = left_o[9];
    assign lk = left_o[10];
    assign ll = left_o[11];
    assign lm = left_o[12];

    assign ra = right_o[0];
    assign rb = right_o[1];
    assign rc = right_o[2];
    assign rd = right_o[3];
    assign re = right_o[4];
    assign rf = right_o[5];
    assign rg = right_o[6];
    assign rh = right_o[7];
    assign ri = right_o[8];
    assign rj = right_o[9];
    assign rk = right_o[10];
    assign rl = right_o[11];

endmodule

// File: tb/tb_led_bank_sequencer.sv
// Bench for led_bank_sequencer: two instances (TICK_DIV=1 and TICK_DIV=3)
// share clock and reset; a cycle-count model pushes expected patterns into a
// scoreboard queue that is popped after each clock edge.
module tb_led_bank_sequencer;

    localparam int FS     = 4;
    localparam int PERIOD = 13 + 12 + FS;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    wire [12:0] l1, l3;
    wire [11:0] r1, r3;

    led_bank_sequencer #(.TICK_DIV(1), .FLASH_STEPS(FS)) dut1 (
        .clk(clk), .reset(reset),
        .la(l1[0]), .lb(l1[1]), .lc(l1[2]), .ld(l1[3]), .le(l1[4]), .lf(l1[5]),
        .lg(l1[6]), .lh(l1[7]), .li(l1[8]), .lj(l1[9]), .lk(l1[10]), .ll(l1[11]),
        .lm(l1[12]),
        .ra(r1[0]), .rb(r1[1]), .rc(r1[2]), .rd(r1[3]), .re(r1[4]), .rf(r1[5]),
        .rg(r1[6]), .rh(r1[7]), .ri(r1[8]), .rj(r1[9]), .rk(r1[10]), .rl(r1[11])
    );

    led_bank_sequencer #(.TICK_DIV(3), .FLASH_STEPS(FS)) dut3 (
        .clk(clk), .reset(reset),
        .la(l3[0]), .lb(l3[1]), .lc(l3[2]), .ld(l3[3]), .le(l3[4]), .lf(l3[5]),
        .lg(l3[6]), .lh(l3[7]), .li(l3[8]), .lj(l3[9]), .lk(l3[10]), .ll(l3[11]),
        .lm(l3[12]),
        .ra(r3[0]), .rb(r3[1]), .rc(r3[2]), .rd(r3[3]), .re(r3[4]), .rf(r3[5]),
        .rg(r3[6]), .rh(r3[7]), .ri(r3[8]), .rj(r3[9]), .rk(r3[10]), .rl(r3[11])
    );

    typedef struct {
        int          k;
        logic [24:0] e1;
        logic [24:0] e3;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   k = 0;

`ifdef LED_ACTIVE_LOW_EN
    localparam logic [24:0] POL = {25{1'b1}};
`else
    localparam logic [24:0] POL = '0;
`endif

    // Expected pattern {right, left} after kk clock edges since release.
    function automatic logic [24:0] model(input int kk, input int td);
        logic [24:0] v;
        int s;
        s = (kk / td) % PERIOD;
        v = '0;
        if (s < 13)
            v[s] = 1'b1;
        else if (s < 25)
            v[s] = 1'b1;
        else if (((s - 25) % 2) == 0)
            v = {25{1'b1}};
        return v ^ POL;
    endfunction

    task automatic clock_and_compare(input string name);
        exp_t e;
        sb.push_back('{k, model(k, 1), model(k, 3)});
        @(posedge clk);
        #1;
        e = sb.pop_front();
        checks++;
        if ({r1, l1} !== e.e1) begin
            errors++;
            $display("FAIL %s td1 k=%0d got=%07h exp=%07h", name, e.k, {r1, l1}, e.e1);
        end
        checks++;
        if ({r3, l3} !== e.e3) begin
            errors++;
            $display("FAIL %s td3 k=%0d got=%07h exp=%07h", name, e.k, {r3, l3}, e.e3);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        k = 0;
        for (int i = 0; i < 2; i++) clock_and_compare("reset");
        checks++;
        if (l1[0] !== ~POL[0] || l3[0] !== ~POL[0]) begin
            errors++;
            $display("FAIL reset_la got=%b/%b exp=%b", l1[0], l3[0], ~POL[0]);
        end
    endtask

    // Two full TICK_DIV=3 periods = six TICK_DIV=1 periods.
    task automatic test_sequence();
        reset = 1'b1;
        for (int i = 0; i < 2 * PERIOD * 3; i++) begin
            k++;
            clock_and_compare("sequence");
            if (k == 13) begin
                checks++;
                if (r1[0] !== ~POL[0] || l1 !== POL[12:0]) begin
                    errors++;
                    $display("FAIL handoff got l=%04h ra=%b", l1, r1[0]);
                end
            end
            if (k == 25) begin
                checks++;
                if ({r1, l1} !== ~POL) begin
                    errors++;
                    $display("FAIL flash_on got=%07h exp=%07h", {r1, l1}, ~POL);
                end
            end
            if (k == 3) begin
                checks++;
                if (l3[1] !== ~POL[1]) begin
                    errors++;
                    $display("FAIL prescale_lb got=%b exp=%b", l3[1], ~POL[1]);
                end
            end
        end
    endtask

    task automatic test_mid_reset();
        while ((k % PERIOD) != 18) begin
            k++;
            clock_and_compare("pre_mid");
        end
        checks++;
        if (r1[5] !== ~POL[18]) begin
            errors++;
            $display("FAIL mid_rf got=%b exp=%b", r1[5], ~POL[18]);
        end
        reset = 1'b0;
        k = 0;
        clock_and_compare("mid_reset");
        reset = 1'b1;
        for (int i = 0; i < PERIOD * 3 + 3; i++) begin
            k++;
            clock_and_compare("after_mid");
        end
    endtask

    initial begin
        test_reset();
        test_sequence();
        test_mid_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
